mmio_timer_irq: RTL and testbench
=================================

Name: mmio_timer_irq

Overview:
- Memory-mapped countdown timer and interrupt source; a responder on the processor's data-memory bus (memaddr/memwrite/memread/be/writedata/readdata).
- Drives the processor's active-low nIRQ input.
- Sits beside data memory in the system block. The system read-data mux selects this block's readdata when the address falls in its window.
- Processor is single-cycle, so reads are combinational and writes commit on the clock edge.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte base of the 32-byte register window; memaddr[31:5] must equal BASE_ADDR[31:5].
- PRESC_W, 16, width of the prescaler register and counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- memaddr  in  32  byte address from the processor; bits [1:0] ignored.
- memwrite  in  1  write strobe, valid for the whole cycle.
- memread  in  1  read qualifier; reads have no side effects, so it only gates readdata.
- be  in  4  byte-lane enables for writes; be[i] covers writedata[8i+7:8i].
- writedata  in  32  write data.
- readdata  out  32  combinational read data; 0 when not hit or memread=0.
- hit  out  1  combinational window decode, used by the system read mux.
- nIRQ  out  1  active-low interrupt = ~(PEND & IRQ_EN), driven from flops only.

Behaviour:
- Register map (offset = memaddr[4:2]):
  - 0 LOAD[31:0]
  - 1 VALUE[31:0]
  - 2 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
  - 3 STATUS: bit0 PEND, write-1-to-clear
  - 4 PRESC[PRESC_W-1:0]
  - 5..7 reserved: read 0, writes ignored
- Reset (sync):
  - LOAD, VALUE, CTRL, STATUS, PRESC and prescaler counter all 0.
  - nIRQ=1; readdata=0 whenever not hit.
- Write (hit & memwrite at posedge): only lanes with be set are updated; bits above a register's width are ignored.
  - LOAD write also copies the merged LOAD value into VALUE and clears the prescaler counter.
  - STATUS write clears PEND where writedata[0]=1 and be[0]=1.
- Read: readdata = register at offset, zero-extended; no state change.
- Prescaler:
  - When EN=1, pcnt increments each cycle.
  - When pcnt==PRESC, tick=1 and pcnt goes to 0. PRESC=0 gives a tick every cycle.
  - EN=0 holds pcnt at 0.
- Countdown on tick with EN=1:
  - VALUE>1: VALUE-1.
  - VALUE==1: VALUE becomes 0 and PEND is set. Then if PERIODIC, VALUE=LOAD; otherwise EN is cleared (one-shot).
  - VALUE==0: no decrement, no event (avoids wrap to 32'hFFFFFFFF).
- Timing: PEND is set on the posedge where VALUE goes 1→0. nIRQ falls the same cycle if IRQ_EN=1 (combinational from PEND/IRQ_EN flops).
- Simultaneous events:
  - Expiry and STATUS W1C in the same cycle: set wins, PEND stays 1.
  - Software write to VALUE or LOAD in the same cycle as a decrement: the write wins, no expiry is evaluated.
  - CTRL write with EN=0 on a tick cycle: the write wins, no decrement.
  - CTRL write in the same cycle as a one-shot auto-clear of EN: the written EN wins.
- IRQ_EN only masks nIRQ; PEND still latches while IRQ_EN=0.
- Reset mid-count: everything returns to reset values on that edge; no PEND, nIRQ=1.

Decomposition:
- Shared package holds:
  - register offset constants (OFF_LOAD..OFF_PRESC);
  - CTRL bit indices (CTRL_EN, CTRL_PERIODIC, CTRL_IRQEN) and STATUS_PEND;
  - the default BASE_ADDR.
- One natural sub-module: timer_prescaler (PRESC in, EN in, tick out). The register file, byte-lane merge and countdown stay in the top level.

Test Plan:
- Reset then read all offsets 0..7 → every read returns 0, nIRQ=1, hit=1 only for BASE_ADDR..BASE_ADDR+0x1C.
- Write LOAD=3, PRESC=0, CTRL=5 (EN, IRQ_EN, one-shot) → VALUE reads 3,2,1,0 over consecutive cycles. nIRQ falls on the 1→0 edge, CTRL.EN reads 0, VALUE stays 0.
- Periodic: LOAD=2, PRESC=1, CTRL=7 → PEND every 4 cycles with VALUE reloaded to 2. W1C STATUS=1 drops nIRQ back to 1; nIRQ falls again on the next expiry.
- Byte enables: LOAD=32'h11223344, then write 32'hAABBCCDD with be=4'b0010 → LOAD reads 32'h1122CC44.
- Collision: issue STATUS W1C in the exact expiry cycle → PEND reads 1, nIRQ stays 0. Write VALUE=10 on a tick cycle → VALUE reads 10.
- IRQ mask and reset: expire with IRQ_EN=0 → STATUS=1, nIRQ=1. Setting IRQ_EN drops nIRQ. Asserting reset mid-count → all registers 0, nIRQ=1 after that edge.

Source files
------------

// File: rtl/mmio_timer_irq_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets, bit indices, default base.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mmio_timer_irq_pkg;

  // Default byte base of the 32-byte register window.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  // Word offsets within the window (memaddr[4:2]).
  localparam logic [2:0] OFF_LOAD   = 3'd0;
  localparam logic [2:0] OFF_VALUE  = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;

  // CTRL register layout.
  localparam int CTRL_W        = 3;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQEN    = 2;

  // STATUS register layout.
  localparam int STATUS_PEND = 0;

  // Byte-lane merge: lanes with be set take the new data, others keep the old word.
  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  lanes);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mmio_timer_irq_prescaler.sv
// Prescaler: divides clk by (presc+1) while enabled and emits a one-cycle tick on terminal count.
// Latency: tick is combinational from the counter flop; counter updates on posedge clk.
// Backpressure: none; free-running while en=1, held at 0 while en=0 or clr=1.
module timer_prescaler
  #(
    parameter int PRESC_W = 16
  )
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
  );

  logic [PRESC_W-1:0] pcnt;

  // Terminal count reached while running; presc=0 ticks every cycle.
  assign tick = en && (pcnt == presc);

  // Count up, wrap to 0 on terminal count; disabled or restarted timers hold at 0.
  always_ff @(posedge clk) begin
    if (reset || !en || clr) begin
      pcnt <= '0;
    end else if (pcnt == presc) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer_irq.sv
// Memory-mapped countdown timer with active-low interrupt, responder on the data-memory bus.
// Latency: reads are combinational; writes commit on the posedge; nIRQ is a pure function of flops.
// Backpressure: none; every access completes in the cycle it is presented.
module mmio_timer_irq
  import mmio_timer_irq_pkg::*;
  #(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESC_W   = 16
  )
  (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        nIRQ
  );

  // Architectural state.
  logic [31:0]        load_q;
  logic [31:0]        value_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               pend_q;
  logic [PRESC_W-1:0] presc_q;

  // Decode.
  logic [2:0] offset;
  logic       wr;
  logic       wr_load;
  logic       wr_value;
  logic       wr_ctrl;
  logic       wr_status;
  logic       wr_presc;

  // Byte-merged write words (current register zero-extended, then lanes replaced).
  logic [31:0] ctrl_ext;
  logic [31:0] presc_ext;
  logic [31:0] load_merged;
  logic [31:0] value_merged;
  logic [31:0] ctrl_merged;
  logic [31:0] presc_merged;

  // Countdown control.
  logic tick;
  logic count_ok;
  logic expire;
  logic w1c_pend;

  assign offset    = memaddr[4:2];
  assign hit       = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign wr        = hit && memwrite;
  assign wr_load   = wr && (offset == OFF_LOAD);
  assign wr_value  = wr && (offset == OFF_VALUE);
  assign wr_ctrl   = wr && (offset == OFF_CTRL);
  assign wr_status = wr && (offset == OFF_STATUS);
  assign wr_presc  = wr && (offset == OFF_PRESC);

  // Zero-extend the narrow registers to bus width for merge and readback.
  always_comb begin
    ctrl_ext                 = '0;
    ctrl_ext[CTRL_W-1:0]     = ctrl_q;
    presc_ext                = '0;
    presc_ext[PRESC_W-1:0]   = presc_q;
  end

  assign load_merged  = merge_be(load_q,    writedata, be);
  assign value_merged = merge_be(value_q,   writedata, be);
  assign ctrl_merged  = merge_be(ctrl_ext,  writedata, be);
  assign presc_merged = merge_be(presc_ext, writedata, be);

  assign w1c_pend = wr_status && be[0] && writedata[STATUS_PEND];

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (wr_load),
    .presc (presc_q),
    .tick  (tick)
  );

  // A tick only counts when no software write to LOAD/VALUE and no EN=0 CTRL write preempts it.
  always_comb begin
    count_ok = tick && ctrl_q[CTRL_EN] && !wr_load && !wr_value
               && !(wr_ctrl && !ctrl_merged[CTRL_EN]);
    expire   = count_ok && (value_q == 32'd1);
  end

  // Register file and countdown; software writes take priority over the timer's own updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q  <= '0;
      value_q <= '0;
      ctrl_q  <= '0;
      pend_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      if (wr_load) begin
        load_q  <= load_merged;
        value_q <= load_merged;
      end else if (wr_value) begin
        value_q <= value_merged;
      end else if (count_ok) begin
        if (value_q > 32'd1) begin
          value_q <= value_q - 32'd1;
        end else if (expire) begin
          value_q <= ctrl_q[CTRL_PERIODIC] ? load_q : 32'd0;
        end
      end

      if (wr_ctrl) begin
        ctrl_q <= ctrl_merged[CTRL_W-1:0];
      end else if (expire && !ctrl_q[CTRL_PERIODIC]) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (expire) begin
        pend_q <= 1'b1;
      end else if (w1c_pend) begin
        pend_q <= 1'b0;
      end

      if (wr_presc) begin
        presc_q <= presc_merged[PRESC_W-1:0];
      end
    end
  end

  // Combinational readback, zero outside the window or without a read qualifier.
  always_comb begin
    readdata = '0;
    if (hit && memread) begin
      case (offset)
        OFF_LOAD:   readdata = load_q;
        OFF_VALUE:  readdata = value_q;
        OFF_CTRL:   readdata = ctrl_ext;
        OFF_STATUS: readdata = {31'd0, pend_q};
        OFF_PRESC:  readdata = presc_ext;
        default:    readdata = '0;
      endcase
    end
  end

  // Interrupt is asserted low while a pending event is unmasked.
  assign nIRQ = ~(pend_q && ctrl_q[CTRL_IRQEN]);

  // Address byte bits and the upper bits of narrow merges carry no information.
  logic unused_bits;
  assign unused_bits = ^{memaddr[1:0], ctrl_merged[31:CTRL_W], presc_merged[31:PRESC_W]};

endmodule

// File: tb/tb_mmio_timer_irq.sv
// Directed self-checking bench for mmio_timer_irq.
// Latency: reads sampled 1 ns into a cycle, writes committed on the following posedge.
// Backpressure: none exercised; the bus has no stall.
module tb_mmio_timer_irq;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD   = BASE + 32'h00;
  localparam logic [31:0] A_VALUE  = BASE + 32'h04;
  localparam logic [31:0] A_CTRL   = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;
  localparam logic [31:0] A_RSV5   = BASE + 32'h14;

  logic        clk;
  logic        reset;
  logic [31:0] memaddr;
  logic        memwrite;
  logic        memread;
  logic [3:0]  be;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        hit;
  logic        nIRQ;

  int errors;
  int checks;

  mmio_timer_irq dut (
    .clk       (clk),
    .reset     (reset),
    .memaddr   (memaddr),
    .memwrite  (memwrite),
    .memread   (memread),
    .be        (be),
    .writedata (writedata),
    .readdata  (readdata),
    .hit       (hit),
    .nIRQ      (nIRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] lanes);
    @(negedge clk);
    memaddr   = addr;
    writedata = data;
    be        = lanes;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
    be        = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    memaddr = addr;
    memread = 1'b1;
    #1;
    data    = readdata;
    memread = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] probe_addr [4];
    logic        probe_hit  [4];
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'(i * 4), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_read off=%0d got=%h want=%h", i, d, 32'd0);
      end
    end
    checks++;
    if (nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL reset_nirq got=%b want=1", nIRQ);
    end
    probe_addr[0] = BASE;            probe_hit[0] = 1'b1;
    probe_addr[1] = BASE + 32'h1C;   probe_hit[1] = 1'b1;
    probe_addr[2] = BASE + 32'h20;   probe_hit[2] = 1'b0;
    probe_addr[3] = BASE - 32'h04;   probe_hit[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memaddr = probe_addr[i];
      #1;
      checks++;
      if (hit !== probe_hit[i]) begin
        errors++;
        $display("FAIL hit_decode addr=%h got=%b want=%b", probe_addr[i], hit, probe_hit[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd3; exp_v[1] = 32'd2; exp_v[2] = 32'd1; exp_v[3] = 32'd0;
    bus_write(A_LOAD, 32'd3, 4'hF);
    bus_write(A_PRESC, 32'd0, 4'hF);
    bus_write(A_CTRL, 32'd5, 4'hF);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step(1);
      bus_read(A_VALUE, d);
      checks++;
      if (d !== exp_v[i]) begin
        errors++;
        $display("FAIL oneshot_value step=%0d got=%0d want=%0d", i, d, exp_v[i]);
      end
      checks++;
      if (nIRQ !== (i == 3 ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL oneshot_nirq step=%0d got=%b want=%b", i, nIRQ, (i == 3 ? 1'b0 : 1'b1));
      end
    end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL oneshot_ctrl got=%h want=%h", d, 32'd4);
    end
    step(2);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_hold got=%0d want=0", d);
    end
    bus_write(A_STATUS, 32'd1, 4'h1);
    checks++;
    if (nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_w1c nirq got=%b want=1", nIRQ);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    bus_write(A_LOAD, 32'd2, 4'hF);
    bus_write(A_PRESC, 32'd1, 4'hF);
    bus_write(A_CTRL, 32'd7, 4'hF);
    step(3);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd1 || nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL periodic_pre value=%0d nirq=%b want value=1 nirq=1", d, nIRQ);
    end
    step(1);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd2 || nIRQ !== 1'b0) begin
      errors++;
      $display("FAIL periodic_expire1 value=%0d nirq=%b want value=2 nirq=0", d, nIRQ);
    end
    bus_write(A_STATUS, 32'd1, 4'h1);
    checks++;
    if (nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL periodic_w1c nirq got=%b want=1", nIRQ);
    end
    step(2);
    checks++;
    if (nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL periodic_gap nirq got=%b want=1", nIRQ);
    end
    step(1);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd2 || nIRQ !== 1'b0) begin
      errors++;
      $display("FAIL periodic_expire2 value=%0d nirq=%b want value=2 nirq=0", d, nIRQ);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    // Next periodic expiry is four edges after the previous one; commit W1C on it.
    step(3);
    bus_write(A_STATUS, 32'd1, 4'h1);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'd1 || nIRQ !== 1'b0) begin
      errors++;
      $display("FAIL collide_w1c status=%0d nirq=%b want status=1 nirq=0", d, nIRQ);
    end
    step(1);
    bus_write(A_VALUE, 32'd10, 4'hF);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL collide_value_write got=%0d want=10", d);
    end
    step(1);
    bus_write(A_CTRL, 32'd4, 4'hF);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL collide_ctrl_disable got=%0d want=10", d);
    end
    bus_write(A_STATUS, 32'd1, 4'h1);
  endtask

  task automatic test_byte_enables();
    logic [31:0] d;
    bus_write(A_LOAD, 32'h1122_3344, 4'hF);
    bus_write(A_LOAD, 32'hAABB_CCDD, 4'b0010);
    bus_read(A_LOAD, d);
    checks++;
    if (d !== 32'h1122_CC44) begin
      errors++;
      $display("FAIL be_load got=%h want=%h", d, 32'h1122_CC44);
    end
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'h1122_CC44) begin
      errors++;
      $display("FAIL be_value_copy got=%h want=%h", d, 32'h1122_CC44);
    end
    memaddr = A_LOAD;
    memread = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL read_gate got=%h want=0", readdata);
    end
    bus_write(A_RSV5, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_RSV5, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reserved got=%h want=0", d);
    end
  endtask

  task automatic test_mask_and_reset();
    logic [31:0] d;
    bus_write(A_PRESC, 32'd0, 4'hF);
    bus_write(A_LOAD, 32'd1, 4'hF);
    bus_write(A_CTRL, 32'd1, 4'hF);
    step(1);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'd1 || nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL mask_pend status=%0d nirq=%b want status=1 nirq=1", d, nIRQ);
    end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL mask_ctrl got=%h want=0", d);
    end
    bus_write(A_CTRL, 32'd4, 4'hF);
    checks++;
    if (nIRQ !== 1'b0) begin
      errors++;
      $display("FAIL mask_unmask nirq got=%b want=0", nIRQ);
    end
    bus_write(A_STATUS, 32'd1, 4'h1);
    bus_write(A_LOAD, 32'd100, 4'hF);
    bus_write(A_CTRL, 32'd5, 4'hF);
    step(3);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd97) begin
      errors++;
      $display("FAIL midcount_value got=%0d want=97", d);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (nIRQ !== 1'b1) begin
      errors++;
      $display("FAIL midreset_nirq got=%b want=1", nIRQ);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 32'(i * 4), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL midreset_read off=%0d got=%h want=0", i, d);
      end
    end
    step(3);
    bus_read(A_VALUE, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL midreset_idle got=%0d want=0", d);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    memaddr   = 32'd0;
    memwrite  = 1'b0;
    memread   = 1'b0;
    be        = 4'h0;
    writedata = 32'd0;
    step(2);
    @(negedge clk);
    reset = 1'b0;
    step(1);

    test_reset();
    test_oneshot();
    test_periodic();
    test_collision();
    test_byte_enables();
    test_mask_and_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
